// File: rtl/dmem_pkg.sv
// Shared types and defaults for the multi-cycle data-memory responder:
// FSM state encoding, default geometry/latency and counter sizing.
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int DMEM_DEPTH_WORDS = 64;
   localparam int DMEM_LATENCY     = 2;
   localparam int DMEM_ADDR_W      = $clog2(DMEM_DEPTH_WORDS);

   // Wide enough to hold latency-1, and never narrower than one bit.
   function automatic int dmemCntWidth(input int latency);
      return (latency <= 2) ? 1 : $clog2(latency);
   endfunction

   localparam int                    DMEM_CNT_W    = dmemCntWidth(DMEM_LATENCY);
   localparam logic [DMEM_CNT_W-1:0] DMEM_CNT_INIT = DMEM_CNT_W'(DMEM_LATENCY - 1);

endpackage

// File: rtl/dmem_array.sv
// Word-wide data storage: synchronous write, combinational read on one address.
// Contents are deliberately not reset so they survive a reset of the responder.
module dmem_array #(
   parameter int DEPTH_WORDS = 64,
   parameter int ADDR_W      = 6
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts mRD/mWR, waits LATENCY cycles, pulses ready.
// Define DMEM_ALIGN_CHK_EN to fault misaligned or out-of-range accesses via err.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
   parameter int LATENCY     = DMEM_LATENCY
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mRD,
   input  logic        mWR,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        stall,
   output logic        err
);

   localparam int               ADDR_W   = $clog2(DEPTH_WORDS);
   localparam int               CNT_W    = dmemCntWidth(LATENCY);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] index_q, index_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              isStore_q, isStore_d;
   logic              fault_q, fault_d;
   logic [31:0]       rdata_q, rdata_d;

   logic              request;
   logic              faultAtAccept;
   logic              memWe;
   logic [31:0]       memRdata;

   assign request = mRD | mWR;

`ifdef DMEM_ALIGN_CHK_EN
   assign faultAtAccept = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH_WORDS));
`else
   // Byte offset and bits above the word index are intentionally dropped (wrap).
   logic unusedAddrBits;
   assign unusedAddrBits = ^{addr[31:ADDR_W+2], addr[1:0]};
   assign faultAtAccept  = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      index_d   = index_q;
      wdata_d   = wdata_q;
      isStore_d = isStore_q;
      fault_d   = fault_q;
      rdata_d   = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (request) begin
               index_d   = addr[ADDR_W+1:2];
               wdata_d   = wdata;
               isStore_d = mWR;
               fault_d   = faultAtAccept;
               count_d   = CNT_INIT;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!request) begin
               state_d = ST_IDLE;
            end else if (count_q == '0) begin
               // Load data is captured here so it is stable for the whole RESP cycle.
               state_d = ST_RESP;
               if (fault_q) begin
                  rdata_d = '0;
               end else if (!isStore_q) begin
                  rdata_d = memRdata;
               end
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         index_q   <= '0;
         wdata_q   <= '0;
         isStore_q <= 1'b0;
         fault_q   <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         index_q   <= index_d;
         wdata_q   <= wdata_d;
         isStore_q <= isStore_d;
         fault_q   <= fault_d;
         rdata_q   <= rdata_d;
      end
   end

   assign ready = (state_q == ST_RESP);
   assign err   = ready & fault_q;
   assign rdata = rdata_q;
   assign stall = request & ~ready;
   assign memWe = ready & isStore_q & ~fault_q;

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (ADDR_W)
   ) u_array (
      .clk     (clk),
      .we_i    (memWe),
      .addr_i  (index_q),
      .wdata_i (wdata_q),
      .rdata_o (memRdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table, abort/reset sequences,
// and randomized accesses against a word-array reference model.
module tb_dmem_responder;

   localparam int DEPTH   = 64;
   localparam int LAT     = 2;
   localparam int EXP_LAT = LAT + 1;
`ifdef DMEM_ALIGN_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        mRD;
   logic        mWR;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        stall;
   logic        err;

   int          nChecks = 0;
   int          nFail   = 0;
   logic [31:0] model [DEPTH];

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] a;
      logic [31:0] wd;
      logic        chkData;
      logic [31:0] expData;
      logic        expErr;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .mRD   (mRD),
      .mWR   (mWR),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .ready (ready),
      .stall (stall),
      .err   (err)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic chk,
                               input logic [31:0] expData, input logic expErr);
      vec_t v;
      v.rd = rd; v.wr = wr; v.a = a; v.wd = wd;
      v.chkData = chk; v.expData = expData; v.expErr = expErr;
      return v;
   endfunction

   // Reference model: word index wraps, offset ignored, faults only when checking is on.
   function automatic void modelAccess(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                                       output logic chkData, output logic [31:0] expData,
                                       output logic expErr);
      int unsigned idx;
      bit          fault;
      idx     = int'((a / 4) % 32'(DEPTH));
      fault   = CHK && (((a % 4) != 0) || ((a / 4) >= 32'(DEPTH)));
      expErr  = fault;
      chkData = fault || !wr;
      expData = '0;
      if (!fault) begin
         if (wr) model[idx] = wd;
         else    expData = model[idx];
      end
   endfunction

   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] wd, output logic gotReady, output int lat,
                                output int stalls, output logic [31:0] rdv, output logic errv,
                                output logic stallAtReady, output logic readyAfter);
      gotReady = 1'b0; lat = -1; stalls = 0; rdv = '0; errv = 1'b0;
      stallAtReady = 1'b0; readyAfter = 1'b0;
      @(posedge clk); #1;
      mRD = rd; mWR = wr; addr = a; wdata = wd;
      for (int k = 0; k < 20 && !gotReady; k++) begin
         @(negedge clk);
         if (ready) begin
            gotReady = 1'b1; lat = k; rdv = rdata; errv = err; stallAtReady = stall;
         end else begin
            if (stall) stalls++;
            if (k == 1) begin
               addr  = $urandom;
               wdata = $urandom;
            end
         end
      end
      @(posedge clk); #1;
      mRD = 1'b0; mWR = 1'b0;
      @(negedge clk);
      readyAfter = ready;
   endtask

   task automatic doAccess(input string name, input vec_t v);
      logic        gotReady, errv, stallAtReady, readyAfter;
      int          lat, stalls;
      logic [31:0] rdv;
      applyStimulus(v.rd, v.wr, v.a, v.wd, gotReady, lat, stalls, rdv, errv, stallAtReady, readyAfter);
      checkOutput({name, ".ready"}, 32'(gotReady), 32'd1);
      if (gotReady) begin
         checkOutput({name, ".latency"}, 32'(lat), 32'(EXP_LAT));
         checkOutput({name, ".stallCycles"}, 32'(stalls), 32'(EXP_LAT));
         checkOutput({name, ".stallAtReady"}, 32'(stallAtReady), 32'd0);
         checkOutput({name, ".readyPulse"}, 32'(readyAfter), 32'd0);
         checkOutput({name, ".err"}, 32'(errv), 32'(v.expErr));
         if (v.chkData) checkOutput({name, ".rdata"}, rdv, v.expData);
      end
   endtask

   task automatic abortAccess(input string name, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] wd);
      logic sawReady;
      sawReady = 1'b0;
      @(posedge clk); #1;
      mRD = rd; mWR = wr; addr = a; wdata = wd;
      @(posedge clk); #1;
      mRD = 1'b0; mWR = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (ready) sawReady = 1'b1;
      end
      checkOutput({name, ".noReady"}, 32'(sawReady), 32'd0);
   endtask

   initial begin
      logic        chk, expErr;
      logic [31:0] expData, ra, rw;
      int          op;
      reset = 1'b0; mRD = 1'b0; mWR = 1'b0; addr = '0; wdata = '0;
      #12;
      checkOutput("reset.ready", 32'(ready), 32'd0);
      checkOutput("reset.rdata", rdata, 32'd0);
      checkOutput("reset.err", 32'(err), 32'd0);
      checkOutput("reset.stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      $display("[TB] reset released, running vector table");

`ifdef DMEM_ALIGN_CHK_EN
      vecs.push_back(mk(0, 1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0));
      vecs.push_back(mk(1, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0));
      vecs.push_back(mk(0, 1, 32'h4, 32'h4444, 1, 32'hDEADBEEF, 0));
      vecs.push_back(mk(0, 1, 32'h6, 32'h1111, 1, 32'h0, 1));
      vecs.push_back(mk(1, 0, 32'h4, 32'h0, 1, 32'h4444, 0));
      vecs.push_back(mk(0, 1, 32'h0, 32'h3333, 0, 32'h0, 0));
      vecs.push_back(mk(0, 1, 32'h400, 32'h2222, 1, 32'h0, 1));
      vecs.push_back(mk(1, 0, 32'h0, 32'h0, 1, 32'h3333, 0));
      vecs.push_back(mk(1, 0, 32'h6, 32'h0, 1, 32'h0, 1));
      vecs.push_back(mk(1, 1, 32'h8, 32'h77, 0, 32'h0, 0));
      vecs.push_back(mk(1, 0, 32'h8, 32'h0, 1, 32'h77, 0));
`else
      vecs.push_back(mk(0, 1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0));
      vecs.push_back(mk(1, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0));
      vecs.push_back(mk(0, 1, 32'h100, 32'h55, 1, 32'hDEADBEEF, 0));
      vecs.push_back(mk(1, 0, 32'h000, 32'h0, 1, 32'h55, 0));
      vecs.push_back(mk(1, 1, 32'h4, 32'h77, 1, 32'h55, 0));
      vecs.push_back(mk(1, 0, 32'h4, 32'h0, 1, 32'h77, 0));
      vecs.push_back(mk(1, 0, 32'h13, 32'h0, 1, 32'hDEADBEEF, 0));
      vecs.push_back(mk(0, 1, 32'hFC, 32'hA5A5A5A5, 0, 32'h0, 0));
      vecs.push_back(mk(1, 0, 32'h1FC, 32'h0, 1, 32'hA5A5A5A5, 0));
      vecs.push_back(mk(1, 0, 32'hFFFFFF10, 32'h0, 1, 32'hDEADBEEF, 0));
`endif
      for (int i = 0; i < vecs.size(); i++) begin
         doAccess($sformatf("vec%0d", i), vecs[i]);
      end

      $display("[TB] abort sequences");
      doAccess("abort.pre", mk(0, 1, 32'h20, 32'h600D, 0, 32'h0, 0));
      abortAccess("abort.load", 1, 0, 32'h20, 32'h0);
      abortAccess("abort.store", 0, 1, 32'h20, 32'hBAD);
      doAccess("abort.check", mk(1, 0, 32'h20, 32'h0, 1, 32'h600D, 0));
      doAccess("abort.newStore", mk(0, 1, 32'h20, 32'h7777, 0, 32'h0, 0));
      doAccess("abort.newLoad", mk(1, 0, 32'h20, 32'h0, 1, 32'h7777, 0));

      $display("[TB] reset during wait");
      doAccess("rst.pre", mk(0, 1, 32'h8, 32'hCAFE, 0, 32'h0, 0));
      doAccess("rst.preLoad", mk(1, 0, 32'h8, 32'h0, 1, 32'hCAFE, 0));
      @(posedge clk); #1;
      mWR = 1'b1; addr = 32'h8; wdata = 32'h1234;
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      checkOutput("rst.ready", 32'(ready), 32'd0);
      checkOutput("rst.rdata", rdata, 32'd0);
      mWR = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      doAccess("rst.postLoad", mk(1, 0, 32'h8, 32'h0, 1, 32'hCAFE, 0));

      $display("[TB] randomized accesses against model");
      for (int i = 0; i < DEPTH; i++) begin
         rw = $urandom;
         modelAccess(1'b1, 32'(i * 4), rw, chk, expData, expErr);
         doAccess($sformatf("fill%0d", i), mk(0, 1, 32'(i * 4), rw, chk, expData, expErr));
      end
      for (int i = 0; i < 80; i++) begin
         op = $urandom_range(0, 2);
         if ($urandom_range(0, 3) == 0) ra = $urandom;
         else                           ra = 32'($urandom_range(0, DEPTH - 1) * 4);
         rw = $urandom;
         modelAccess(op != 0, ra, rw, chk, expData, expErr);
         doAccess($sformatf("rand%0d", i),
                  mk(op != 1, op != 0, ra, rw, chk, expData, expErr));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
